// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one serial TX line between NUM_REQ byte sources.
// Bit timing follows an external one-cycle baud tick; frames are 1 start, DATA_BITS data, STOP_BITS stop.
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           baud_tick,
  input  logic [NUM_REQ-1:0]                             req,
  input  logic [NUM_REQ*DATA_BITS-1:0]                   din,
  output logic [NUM_REQ-1:0]                             ack,
  output logic                                           tx,
  output logic                                           busy,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic [IW-1:0]        ptr, ptr_n, grant_n, sel, cand;
  logic                 found;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [CW-1:0]        bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 tx_n, busy_n;
  logic [NUM_REQ-1:0]   ack_n;

  // First pending requester strictly after the last grant, wrapping at NUM_REQ-1.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (cand == IW'(NUM_REQ - 1)) cand = '0;
      else                          cand = cand + 1'b1;
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    grant_n    = grant_idx;
    shift_n    = shift;
    bit_cnt_n  = bit_cnt;
    stop_cnt_n = stop_cnt;
    tx_n       = tx;
    busy_n     = busy;
    ack_n      = '0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (found) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IW'(i)) shift_n = din[i*DATA_BITS +: DATA_BITS];
          end
          ack_n[sel] = 1'b1;
          grant_n    = sel;
          ptr_n      = sel;
          busy_n     = 1'b1;
          state_n    = ALIGN;
        end
      end
      ALIGN: begin
        tx_n = 1'b1;
        if (baud_tick) begin
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_tick) begin
          tx_n      = shift[0];
          shift_n   = shift >> 1;
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end
      // bit_cnt counts data bits already on the line beyond bit 0.
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt == CW'(DATA_BITS - 1)) begin
            tx_n       = 1'b1;
            stop_cnt_n = 1'b0;
            state_n    = STOP;
          end else begin
            tx_n      = shift[0];
            shift_n   = shift >> 1;
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= IW'(NUM_REQ - 1);
      grant_idx <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      ack       <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      grant_idx <= grant_n;
      shift     <= shift_n;
      bit_cnt   <= bit_cnt_n;
      stop_cnt  <= stop_cnt_n;
      tx        <= tx_n;
      busy      <= busy_n;
      ack       <= ack_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: one 8N1 instance and one 8N2 instance share clock and baud tick.
// Stimulus pushes expected acks/frames; a negedge monitor decodes tx and pops/compares.
module tb_uart_tx_arbiter;

  localparam int TICK_DIV = 16;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic [3:0] req_v   [2];
  logic [31:0] din_v  [2];
  logic [3:0] ack_w   [2];
  logic       tx_w    [2];
  logic       busy_w  [2];
  logic [1:0] grant_w [2];

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req_v[0]), .din(din_v[0]),
    .ack(ack_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .grant_idx(grant_w[0])
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .STOP_BITS(2)) dut_2stop (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .req(req_v[1]), .din(din_v[1]),
    .ack(ack_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .grant_idx(grant_w[1])
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] src_byte [2][4][8];
  int         src_cnt  [2][4];
  int         src_rd   [2][4];
  logic [3:0] pulse    [2];

  logic [2:0]  exp_ack_q [$];
  logic [10:0] exp_frm_q [$];

  int         dst        [2];
  int         nbits      [2];
  int         nstop      [2];
  logic [7:0] dbyte      [2];
  logic [1:0] dgrant     [2];
  bit         busy_chk   [2];
  int         last_start [2];
  int         gap        [2];
  int         tick_num = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TICK_DIV) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out, got no response, expected completion", name);
  endtask

  task automatic applyStimulus(input int ch, input int idx, input logic [7:0] b);
    src_byte[ch][idx][src_cnt[ch][idx]] = b;
    src_cnt[ch][idx]++;
  endtask

  task automatic expect_grant(input int ch, input int idx, input logic [7:0] b, input bit framed);
    exp_ack_q.push_back({1'(ch), 2'(idx)});
    if (framed) exp_frm_q.push_back({1'(ch), 2'(idx), b});
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  function automatic bit all_idle();
    bit r;
    r = (exp_ack_q.size() == 0) && (exp_frm_q.size() == 0);
    for (int c = 0; c < 2; c++) begin
      if (busy_w[c] || dst[c] != 0) r = 1'b0;
      for (int i = 0; i < 4; i++) if (src_rd[c][i] < src_cnt[c][i]) r = 1'b0;
    end
    return r;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeout_fail(name);
  endtask

  task automatic check_reset_state(input string name);
    for (int c = 0; c < 2; c++) begin
      checkOutput({name, "_tx"},    32'(tx_w[c]),    32'h1);
      checkOutput({name, "_busy"},  32'(busy_w[c]),  32'h0);
      checkOutput({name, "_ack"},   32'(ack_w[c]),   32'h0);
      checkOutput({name, "_grant"}, 32'(grant_w[c]), 32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
  endtask

  // Requester model: hold req and din until ack, then present the next queued byte.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        for (int i = 0; i < 4; i++) begin
          if (ack_w[c][i] && src_rd[c][i] < src_cnt[c][i]) src_rd[c][i]++;
          req_v[c][i] = (src_rd[c][i] < src_cnt[c][i]) || pulse[c][i];
          din_v[c][i*8 +: 8] = (src_rd[c][i] < src_cnt[c][i]) ? src_byte[c][i][src_rd[c][i]] : 8'h00;
        end
        pulse[c] = 4'b0000;
      end
    end
  end

  task automatic monitor_channel(input int c);
    logic [2:0]  ea;
    logic [10:0] ef;
    if (rst) begin
      dst[c]      = 0;
      busy_chk[c] = 1'b0;
      return;
    end
    if (busy_chk[c]) begin
      checkOutput("busy_after_stop", 32'(busy_w[c]), 32'h0);
      busy_chk[c] = 1'b0;
    end
    if (ack_w[c] != 4'b0000) begin
      if (exp_ack_q.size() == 0) begin
        checkOutput("unexpected_ack", 32'(ack_w[c]), 32'h0);
      end else begin
        ea = exp_ack_q.pop_front();
        checkOutput("ack", 32'({1'(c), ack_w[c]}), 32'({ea[2], 4'(4'b0001 << ea[1:0])}));
      end
    end
    if (baud_tick) begin
      case (dst[c])
        0: begin
          if (tx_w[c] == 1'b0) begin
            dst[c]        = 1;
            nbits[c]      = 0;
            dbyte[c]      = 8'h00;
            dgrant[c]     = grant_w[c];
            gap[c]        = tick_num - last_start[c];
            last_start[c] = tick_num;
            checkOutput("busy_in_frame", 32'(busy_w[c]), 32'h1);
          end
        end
        1: begin
          dbyte[c][nbits[c]] = tx_w[c];
          nbits[c]++;
          if (nbits[c] == 8) begin
            dst[c]   = 2;
            nstop[c] = 0;
          end
        end
        default: begin
          checkOutput("stop_bit", 32'(tx_w[c]), 32'h1);
          nstop[c]++;
          if (nstop[c] == c + 1) begin
            dst[c]      = 0;
            busy_chk[c] = 1'b1;
            if (exp_frm_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL unexpected_frame: got ch%0d grant %0d byte %0h, expected no frame",
                       c, dgrant[c], dbyte[c]);
            end else begin
              ef = exp_frm_q.pop_front();
              checkOutput("frame", 32'({1'(c), dgrant[c], dbyte[c]}), 32'(ef));
            end
          end
        end
      endcase
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (baud_tick) tick_num++;
      for (int c = 0; c < 2; c++) monitor_channel(c);
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_v[c]      = 4'b0000;
      din_v[c]      = 32'h0;
      pulse[c]      = 4'b0000;
      dst[c]        = 0;
      nbits[c]      = 0;
      nstop[c]      = 0;
      dbyte[c]      = 8'h00;
      dgrant[c]     = 2'd0;
      busy_chk[c]   = 1'b0;
      last_start[c] = 0;
      gap[c]        = 0;
      for (int i = 0; i < 4; i++) begin
        src_cnt[c][i] = 0;
        src_rd[c][i]  = 0;
      end
    end

    do_reset();
    check_reset_state("reset");

    $display("[TB] single byte 0x55 from requester 0");
    applyStimulus(0, 0, 8'h55);
    expect_grant(0, 0, 8'h55, 1'b1);
    wait_idle("single_byte", 3000);

    $display("[TB] all four pending: rotation 0,1,2,3,0");
    do_reset();
    applyStimulus(0, 0, 8'hA0);
    applyStimulus(0, 0, 8'hB0);
    applyStimulus(0, 1, 8'hA1);
    applyStimulus(0, 2, 8'hA2);
    applyStimulus(0, 3, 8'hA3);
    expect_grant(0, 0, 8'hA0, 1'b1);
    expect_grant(0, 1, 8'hA1, 1'b1);
    expect_grant(0, 2, 8'hA2, 1'b1);
    expect_grant(0, 3, 8'hA3, 1'b1);
    expect_grant(0, 0, 8'hB0, 1'b1);
    wait_idle("rotation", 6000);

    $display("[TB] skip and wrap: grant 1, then 1010 gives 3 then 1");
    applyStimulus(0, 1, 8'h11);
    expect_grant(0, 1, 8'h11, 1'b1);
    wait_idle("grant1", 3000);
    applyStimulus(0, 1, 8'h12);
    applyStimulus(0, 3, 8'h33);
    expect_grant(0, 3, 8'h33, 1'b1);
    expect_grant(0, 1, 8'h12, 1'b1);
    wait_idle("wrap", 4000);

    $display("[TB] single requester back-to-back");
    applyStimulus(0, 2, 8'h21);
    applyStimulus(0, 2, 8'h22);
    expect_grant(0, 2, 8'h21, 1'b1);
    expect_grant(0, 2, 8'h22, 1'b1);
    wait_idle("back_to_back", 4000);
    checkOutput("gap_8n1", 32'(gap[0]), 32'd11);

    $display("[TB] one-clock req[2] pulse while busy");
    applyStimulus(0, 0, 8'h5A);
    expect_grant(0, 0, 8'h5A, 1'b1);
    n = 0;
    while (!busy_w[0] && n < 100) begin
      step();
      n++;
    end
    if (n >= 100) timeout_fail("pulse_busy");
    pulse[0] = 4'b0100;
    wait_idle("pulse", 3000);
    repeat (300) step();

    $display("[TB] reset at data bit 4 of 0x3C");
    applyStimulus(0, 2, 8'h3C);
    applyStimulus(0, 2, 8'h3C);
    expect_grant(0, 2, 8'h3C, 1'b0);
    n = 0;
    while (!(dst[0] == 1 && nbits[0] == 4) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) timeout_fail("reach_bit4");
    applyStimulus(0, 3, 8'h0F);
    rst = 1'b1;
    step();
    checkOutput("abort_tx",    32'(tx_w[0]),    32'h1);
    checkOutput("abort_busy",  32'(busy_w[0]),  32'h0);
    checkOutput("abort_ack",   32'(ack_w[0]),   32'h0);
    checkOutput("abort_grant", 32'(grant_w[0]), 32'h0);
    rst = 1'b0;
    expect_grant(0, 2, 8'h3C, 1'b1);
    expect_grant(0, 3, 8'h0F, 1'b1);
    wait_idle("after_abort", 4000);

    $display("[TB] two stop bits: 0xFF then 0x81");
    applyStimulus(1, 0, 8'hFF);
    applyStimulus(1, 0, 8'h81);
    expect_grant(1, 0, 8'hFF, 1'b1);
    expect_grant(1, 0, 8'h81, 1'b1);
    wait_idle("two_stop", 4000);
    checkOutput("gap_8n2", 32'(gap[1]), 32'd12);

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
